input_arguments: RTL and testbench
==================================

// Module: input_arguments
// PURPOSE
//  Run-configuration front end for the split L1 cache model. Parses a byte stream of
//  plusargs ("+MODE=<dec> +FILE=<hex>") and holds the results on two outputs.
//  - file: trace-file descriptor; 0 means "no file", and the consumer stops.
//  - mode: verbosity; 1 enables L2-traffic messages in the cache.
//  Sits between the argument source and the cache top; both outputs are static after args_done.
// PARAMETERS
//  DATA_WIDTH   32  width of file and mode outputs and of the value accumulators
//  DEFAULT_MODE 0   mode value after reset / when +MODE is absent
//  DEFAULT_FILE 0   file value after reset / when +FILE is absent (0 = no file)
//  MAX_KEY_LEN  8   key chars buffered; a longer key is treated as unknown
// PORTS
//  clk        in   1           single clock, all logic on rising edge
//  rst_n      in   1           synchronous, active-low reset
//  char_valid in   1           char_data is valid this cycle
//  char_data  in   8           ASCII argument character
//  char_ready out  1           1 = parser accepts a char; transfer = char_valid & char_ready
//  file       out  DATA_WIDTH  trace-file descriptor
//  mode       out  DATA_WIDTH  run mode
//  args_done  out  1           sticky; set once 0x00 (end of args) is accepted
//  args_error out  1           sticky; set on any malformed token
// BEHAVIOUR
//  - Reset (rst_n=0 at edge):
//    - file=DEFAULT_FILE, mode=DEFAULT_MODE, args_done=0, args_error=0.
//    - char_ready=1, state=SEP, accumulators cleared.
//  - Separators are 0x20, 0x09, 0x0A and 0x0D. The terminator is 0x00.
//  - FSM states: SEP, KEY, VAL, SKIP, DONE. One char is consumed per transfer; idle cycles hold state.
//  - SEP:
//    - separator: stay in SEP.
//    - '+': go to KEY, clear the key buffer.
//    - 0x00: go to DONE.
//    - any other char: set args_error, go to SKIP.
//  - KEY (case-sensitive):
//    - chars are appended to the key buffer.
//    - '=': matches "MODE" -> VAL decimal; matches "FILE" -> VAL hex; anything else -> args_error, SKIP.
//    - separator or 0x00 before '=': set args_error; go to SEP or DONE respectively.
//  - VAL:
//    - decimal: acc = acc*10 + digit.
//    - hex: acc = (acc<<4) | nibble; 0-9, a-f and A-F are accepted.
//    - both are truncated modulo 2^DATA_WIDTH.
//    - any non-digit that is not a separator or 0x00: set args_error, discard the value, go to SKIP.
//    - separator or 0x00 with >=1 digit: commit acc to mode or file on that edge, so it is visible next cycle.
//      Then go to SEP or DONE respectively.
//    - separator or 0x00 with zero digits: set args_error, no commit.
//  - SKIP: discard chars until a separator (-> SEP) or 0x00 (-> DONE).
//  - DONE:
//    - args_done=1, char_ready=0, and all input is ignored until reset.
//    - args_done and the final commit become visible in the same cycle (the one after 0x00 is accepted).
//  - A repeated key: the last valid value wins. An erroneous token never alters file or mode.
//  - char_ready = (state != DONE); there is no back-pressure otherwise.
//  - A reset mid-stream aborts parsing and restores all reset values. Any partial token is lost.
// TESTING
//  - Reset only, no chars -> file=0, mode=0, args_done=0, args_error=0, char_ready=1.
//  - "+MODE=1 +FILE=80000003\0" -> mode=1, file=0x80000003, args_done=1, args_error=0, char_ready=0.
//  - "+MODE=0 +MODE=42\0" -> mode=42 (last wins), file=0, args_error=0.
//  - "+MODE=1x +FILE=a\0" -> mode stays 0, file=0xA, args_error=1, args_done=1.
//  - "+FOO=3 +MODE=\0" -> mode=0, file=0, args_error=1; chars sent after DONE are ignored.
//  - "+MODE=4294967297\0" -> mode=1 (mod 2^32); char_valid gaps between chars give the same result.

Source files
------------

// File: rtl/input_arguments.sv
// -----------------------------------------------------------------------------
// input_arguments
// Run-configuration front end for the split L1 cache model. Consumes a byte
// stream of plusargs ("+MODE=<dec> +FILE=<hex>", terminated by 0x00) and holds
// the parsed values on two static outputs.
//
// Ports
//   clk        in   1           single clock, rising edge
//   rst_n      in   1           synchronous, active-low reset
//   char_valid in   1           char_data is valid this cycle
//   char_data  in   8           ASCII argument character
//   char_ready out  1           parser accepts a char (low only once done)
//   file       out  DATA_WIDTH  trace-file descriptor, 0 = no file
//   mode       out  DATA_WIDTH  run mode / verbosity
//   args_done  out  1           sticky, set once the terminator is accepted
//   args_error out  1           sticky, set on any malformed token
// -----------------------------------------------------------------------------
module input_arguments #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_MODE = {DATA_WIDTH{1'b0}},
  parameter logic [DATA_WIDTH-1:0] DEFAULT_FILE = {DATA_WIDTH{1'b0}},
  parameter int                    MAX_KEY_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  char_valid,
  input  logic [7:0]            char_data,
  output logic                  char_ready,
  output logic [DATA_WIDTH-1:0] file,
  output logic [DATA_WIDTH-1:0] mode,
  output logic                  args_done,
  output logic                  args_error
);

  localparam int KEY_W = MAX_KEY_LEN * 8;
  localparam int LEN_W = $clog2(MAX_KEY_LEN + 2);
  // Key length saturates one past the buffer size so an overlong key never
  // aliases onto a short one.
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_KEY_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_4   = LEN_W'(4);

  localparam logic [31:0] KEY_MODE = 32'h4D4F4445; // "MODE"
  localparam logic [31:0] KEY_FILE = 32'h46494C45; // "FILE"

  typedef enum logic [2:0] {
    ST_SEP  = 3'd0,
    ST_KEY  = 3'd1,
    ST_VAL  = 3'd2,
    ST_SKIP = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t                state_r;
  logic [KEY_W-1:0]      key_buf_r;
  logic [LEN_W-1:0]      key_len_r;
  logic [DATA_WIDTH-1:0] acc_r;
  logic                  is_hex_r;
  logic                  has_digit_r;
  logic [DATA_WIDTH-1:0] file_r;
  logic [DATA_WIDTH-1:0] mode_r;
  logic                  done_r;
  logic                  error_r;
  logic                  ready_r;

  logic                  xfer_s;
  logic                  is_sep_s;
  logic                  is_nul_s;
  logic                  is_plus_s;
  logic                  is_eq_s;
  logic [4:0]            dec_s;
  logic [4:0]            hex_s;
  logic                  digit_ok_s;
  logic [3:0]            digit_s;
  logic [DATA_WIDTH-1:0] acc_next_s;
  logic                  key_is_mode_s;
  logic                  key_is_file_s;

  // Whitespace that separates tokens.
  function automatic logic is_sep(input logic [7:0] c);
    return (c == 8'h20) || (c == 8'h09) || (c == 8'h0A) || (c == 8'h0D);
  endfunction

  // Decimal digit decode: {valid, value}.
  function automatic logic [4:0] dec_digit(input logic [7:0] c);
    if ((c >= 8'h30) && (c <= 8'h39)) begin
      return {1'b1, c[3:0]};
    end else begin
      return 5'b0_0000;
    end
  endfunction

  // Hex digit decode, both letter cases: {valid, value}. Letters a-f / A-F
  // have low nibble 1..6, so adding 9 yields 10..15.
  function automatic logic [4:0] hex_digit(input logic [7:0] c);
    if ((c >= 8'h30) && (c <= 8'h39)) begin
      return {1'b1, c[3:0]};
    end else if (((c >= 8'h61) && (c <= 8'h66)) || ((c >= 8'h41) && (c <= 8'h46))) begin
      return {1'b1, c[3:0] + 4'd9};
    end else begin
      return 5'b0_0000;
    end
  endfunction

  // Character classification and next accumulator value.
  always_comb begin
    xfer_s     = char_valid & ready_r;
    is_sep_s   = is_sep(char_data);
    is_nul_s   = (char_data == 8'h00);
    is_plus_s  = (char_data == 8'h2B);
    is_eq_s    = (char_data == 8'h3D);
    dec_s      = dec_digit(char_data);
    hex_s      = hex_digit(char_data);
    digit_ok_s = 1'b0;
    digit_s    = 4'h0;
    acc_next_s = acc_r;
    if (is_hex_r) begin
      digit_ok_s = hex_s[4];
      digit_s    = hex_s[3:0];
      acc_next_s = {acc_r[DATA_WIDTH-5:0], digit_s};
    end else begin
      digit_ok_s = dec_s[4];
      digit_s    = dec_s[3:0];
      // acc*10 as (acc<<3)+(acc<<1); truncation gives modulo 2^DATA_WIDTH.
      acc_next_s = (acc_r << 3) + (acc_r << 1) + {{(DATA_WIDTH-4){1'b0}}, digit_s};
    end
    key_is_mode_s = (key_len_r == LEN_4) && (key_buf_r[31:0] == KEY_MODE);
    key_is_file_s = (key_len_r == LEN_4) && (key_buf_r[31:0] == KEY_FILE);
  end

  // Parser FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_SEP;
      key_buf_r   <= {KEY_W{1'b0}};
      key_len_r   <= {LEN_W{1'b0}};
      acc_r       <= {DATA_WIDTH{1'b0}};
      is_hex_r    <= 1'b0;
      has_digit_r <= 1'b0;
      file_r      <= DEFAULT_FILE;
      mode_r      <= DEFAULT_MODE;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      ready_r     <= 1'b1;
    end else if (xfer_s) begin
      case (state_r)
        ST_SEP: begin
          if (is_sep_s) begin
            state_r <= ST_SEP;
          end else if (is_plus_s) begin
            state_r   <= ST_KEY;
            key_buf_r <= {KEY_W{1'b0}};
            key_len_r <= {LEN_W{1'b0}};
          end else if (is_nul_s) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
            ready_r <= 1'b0;
          end else begin
            error_r <= 1'b1;
            state_r <= ST_SKIP;
          end
        end
        ST_KEY: begin
          if (is_eq_s) begin
            acc_r       <= {DATA_WIDTH{1'b0}};
            has_digit_r <= 1'b0;
            if (key_is_mode_s) begin
              is_hex_r <= 1'b0;
              state_r  <= ST_VAL;
            end else if (key_is_file_s) begin
              is_hex_r <= 1'b1;
              state_r  <= ST_VAL;
            end else begin
              error_r <= 1'b1;
              state_r <= ST_SKIP;
            end
          end else if (is_sep_s) begin
            error_r <= 1'b1;
            state_r <= ST_SEP;
          end else if (is_nul_s) begin
            error_r <= 1'b1;
            state_r <= ST_DONE;
            done_r  <= 1'b1;
            ready_r <= 1'b0;
          end else begin
            key_buf_r <= {key_buf_r[KEY_W-9:0], char_data};
            if (key_len_r != LEN_SAT) begin
              key_len_r <= key_len_r + {{(LEN_W-1){1'b0}}, 1'b1};
            end
          end
        end
        ST_VAL: begin
          if (digit_ok_s) begin
            acc_r       <= acc_next_s;
            has_digit_r <= 1'b1;
          end else if (is_sep_s || is_nul_s) begin
            if (has_digit_r) begin
              if (is_hex_r) begin
                file_r <= acc_r;
              end else begin
                mode_r <= acc_r;
              end
            end else begin
              error_r <= 1'b1;
            end
            if (is_nul_s) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
              ready_r <= 1'b0;
            end else begin
              state_r <= ST_SEP;
            end
          end else begin
            error_r <= 1'b1;
            state_r <= ST_SKIP;
          end
        end
        ST_SKIP: begin
          if (is_sep_s) begin
            state_r <= ST_SEP;
          end else if (is_nul_s) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
            ready_r <= 1'b0;
          end else begin
            state_r <= ST_SKIP;
          end
        end
        ST_DONE: begin
          state_r <= ST_DONE;
        end
        default: begin
          state_r <= ST_SEP;
        end
      endcase
    end
  end

  assign char_ready = ready_r;
  assign file       = file_r;
  assign mode       = mode_r;
  assign args_done  = done_r;
  assign args_error = error_r;

endmodule

// File: tb/tb_input_arguments.sv
// -----------------------------------------------------------------------------
// tb_input_arguments
// Scoreboard bench for input_arguments: each case pushes its expected final
// outputs when the stimulus is issued, and pops/compares them once the parser
// has accepted the terminator (or after a reset for the reset cases).
// -----------------------------------------------------------------------------
module tb_input_arguments;

  logic        clk;
  logic        rst_n;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic [31:0] file;
  logic [31:0] mode;
  logic        args_done;
  logic        args_error;

  typedef struct packed {
    logic [31:0] file;
    logic [31:0] mode;
    logic        done;
    logic        err;
    logic        ready;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    n_tests;
  int    n_fail;

  input_arguments dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .file       (file),
    .mode       (mode),
    .args_done  (args_done),
    .args_error (args_error)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    char_valid = 1'b0;
    char_data  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One transfer; returns #1 after the edge that samples it.
  task automatic send_char(input logic [7:0] c, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    @(negedge clk);
    char_valid = 1'b1;
    char_data  = c;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
  endtask

  task automatic send_str(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      send_char(s[i], gaps);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] f, input logic [31:0] m,
                          input logic d, input logic e, input logic r);
    exp_t x;
    x.file  = f;
    x.mode  = m;
    x.done  = d;
    x.err   = e;
    x.ready = r;
    sb_q.push_back(x);
    tag_q.push_back(tag);
  endtask

  task automatic pop_cmp();
    exp_t  x;
    string t;
    if (sb_q.size() == 0) begin
      chk_val("sb_empty", 32'd1, 32'd0);
    end else begin
      x = sb_q.pop_front();
      t = tag_q.pop_front();
      chk_val({t, ".file"},  file,                x.file);
      chk_val({t, ".mode"},  mode,                x.mode);
      chk_val({t, ".done"},  {31'd0, args_done},  {31'd0, x.done});
      chk_val({t, ".err"},   {31'd0, args_error}, {31'd0, x.err});
      chk_val({t, ".ready"}, {31'd0, char_ready}, {31'd0, x.ready});
    end
  endtask

  // Full argument string followed by the terminator; outputs are compared in
  // the cycle right after 0x00 is accepted. Optional trailing chars are sent
  // after DONE and must change nothing.
  task automatic run_case(input string tag, input string s, input string post, input bit gaps,
                          input logic [31:0] f, input logic [31:0] m, input logic e);
    do_reset();
    push_exp(tag, f, m, 1'b1, e, 1'b0);
    send_str(s, gaps);
    chk_val({tag, ".pre_done"}, {31'd0, args_done}, 32'd0);
    send_char(8'h00, gaps);
    pop_cmp();
    if (post.len() > 0) begin
      push_exp({tag, ".post"}, f, m, 1'b1, e, 1'b0);
      send_str(post, gaps);
      send_char(8'h00, gaps);
      repeat (3) @(posedge clk);
      #1;
      pop_cmp();
    end
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    char_valid = 1'b0;
    char_data  = 8'h00;

    // Reset only, no characters.
    do_reset();
    push_exp("reset", 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    pop_cmp();

    run_case("basic",    "+MODE=1 +FILE=80000003", "", 1'b0, 32'h80000003, 32'd1, 1'b0);
    run_case("repeat",   "+MODE=0 +MODE=42",       "", 1'b0, 32'd0,        32'd42, 1'b0);
    run_case("badval",   "+MODE=1x +FILE=a",       "", 1'b0, 32'h0000000A, 32'd0, 1'b0 | 1'b1);
    run_case("badkey",   "+FOO=3 +MODE=",   "+MODE=7 +FILE=9", 1'b0, 32'd0, 32'd0, 1'b1);
    run_case("wrap",     "+MODE=4294967297",       "", 1'b0, 32'd0,        32'd1, 1'b0);
    run_case("wrap_gap", "+MODE=4294967297",       "", 1'b1, 32'd0,        32'd1, 1'b0);
    run_case("hexcase",  "+FILE=DeadBEEF\t+MODE=10\r\n", "", 1'b1, 32'hDEADBEEF, 32'd10, 1'b0);
    run_case("longkey",  "+MODEMODEX=1 +FILE=12",  "", 1'b0, 32'h00000012, 32'd0, 1'b1);
    run_case("lower",    "+mode=5",                "", 1'b0, 32'd0,        32'd0, 1'b1);
    run_case("lead",     "x +MODE=3",              "", 1'b0, 32'd0,        32'd3, 1'b1);
    run_case("keysep",   "+MODE +FILE=7",          "", 1'b0, 32'h00000007, 32'd0, 1'b1);

    // Reset in the middle of a stream restores every reset value.
    do_reset();
    push_exp("midreset", 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    send_str("+MODE=5 x +FILE=1", 1'b0);
    chk_val("midreset.pre_mode", mode, 32'd5);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    pop_cmp();
    @(negedge clk);
    rst_n = 1'b1;

    chk_val("sb_drained", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
